// File: rtl/motion_pkg.sv
// Shared defaults, widths and FSM state type for the motion bounding-box tracker.
package motion_pkg;

  localparam int unsigned HActiveDef = 640;
  localparam int unsigned VActiveDef = 480;
  localparam int unsigned XWidth     = 10;
  localparam int unsigned YWidth     = 9;
  localparam int unsigned CntWidth   = 19;

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StPublish
  } state_e;

endpackage

// File: rtl/pixel_coord_counter.sv
// Raster x/y position of the pixel currently presented, with wrap and last-pixel flag.
module pixel_coord_counter #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned X_WIDTH  = 10,
  parameter int unsigned Y_WIDTH  = 9
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear_i,
  input  logic               advance_i,
  output logic [X_WIDTH-1:0] x_o,
  output logic [Y_WIDTH-1:0] y_o,
  output logic               last_o
);

  localparam logic [X_WIDTH-1:0] XLast = X_WIDTH'(H_ACTIVE - 1);
  localparam logic [Y_WIDTH-1:0] YLast = Y_WIDTH'(V_ACTIVE - 1);

  logic [X_WIDTH-1:0] x_q, x_d;
  logic [Y_WIDTH-1:0] y_q, y_d;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clear_i) begin
      x_d = '0;
      y_d = '0;
    end else if (advance_i) begin
      if (x_q == XLast) begin
        x_d = '0;
        y_d = (y_q == YLast) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x_o    = x_q;
  assign y_o    = y_q;
  assign last_o = (x_q == XLast) && (y_q == YLast);

endmodule

// File: rtl/motion_bbox.sv
// Accumulates the bounding box and count of motion pixels per frame and publishes them once
// per complete frame.
module motion_bbox
  import motion_pkg::*;
#(
  parameter int unsigned INPUT_WIDTH = 10,
  parameter int unsigned H_ACTIVE    = HActiveDef,
  parameter int unsigned V_ACTIVE    = VActiveDef,
  parameter int unsigned X_WIDTH     = XWidth,
  parameter int unsigned Y_WIDTH     = YWidth,
  parameter int unsigned CNT_WIDTH   = CntWidth
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   frame_start,
  input  logic                   is_not_blank,
  input  logic [INPUT_WIDTH-1:0] delta_frame,
  input  logic [CNT_WIDTH-1:0]   min_pixels,
  output logic [X_WIDTH-1:0]     bbox_x_min,
  output logic [X_WIDTH-1:0]     bbox_x_max,
  output logic [Y_WIDTH-1:0]     bbox_y_min,
  output logic [Y_WIDTH-1:0]     bbox_y_max,
  output logic [CNT_WIDTH-1:0]   pixel_count,
  output logic                   object_found,
  output logic                   bbox_valid
);

  state_e state_q, state_d;
  logic   pix_valid_q;

  logic [X_WIDTH-1:0]   x_cur;
  logic [Y_WIDTH-1:0]   y_cur;
  logic                 last_flag;

  logic [X_WIDTH-1:0]   acc_x_min_q, acc_x_min_d, acc_x_max_q, acc_x_max_d;
  logic [Y_WIDTH-1:0]   acc_y_min_q, acc_y_min_d, acc_y_max_q, acc_y_max_d;
  logic [CNT_WIDTH-1:0] acc_cnt_q, acc_cnt_d;

  logic [X_WIDTH-1:0]   out_x_min_q, out_x_min_d, out_x_max_q, out_x_max_d;
  logic [Y_WIDTH-1:0]   out_y_min_q, out_y_min_d, out_y_max_q, out_y_max_d;
  logic [CNT_WIDTH-1:0] out_cnt_q, out_cnt_d;
  logic                 out_found_q, out_found_d, out_valid_q, out_valid_d;

  logic take, motion, last_pix, found;

  // frame_start wins over everything, including a coincident last pixel.
  assign take     = (state_q == StAccum) && pix_valid_q && !frame_start;
  assign motion   = take && (delta_frame != '0);
  assign last_pix = take && last_flag;

  pixel_coord_counter #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .X_WIDTH  (X_WIDTH),
    .Y_WIDTH  (Y_WIDTH)
  ) u_coord (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (frame_start),
    .advance_i (take),
    .x_o       (x_cur),
    .y_o       (y_cur),
    .last_o    (last_flag)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    state_d = StIdle;
      StAccum:   if (last_pix) state_d = StPublish;
      StPublish: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
    if (frame_start) state_d = StAccum;
  end

  always_comb begin
    acc_x_min_d = acc_x_min_q;
    acc_x_max_d = acc_x_max_q;
    acc_y_min_d = acc_y_min_q;
    acc_y_max_d = acc_y_max_q;
    acc_cnt_d   = acc_cnt_q;
    if (frame_start) begin
      acc_x_min_d = '1;
      acc_x_max_d = '0;
      acc_y_min_d = '1;
      acc_y_max_d = '0;
      acc_cnt_d   = '0;
    end else if (motion) begin
      if (x_cur < acc_x_min_q) acc_x_min_d = x_cur;
      if (x_cur > acc_x_max_q) acc_x_max_d = x_cur;
      if (y_cur < acc_y_min_q) acc_y_min_d = y_cur;
      if (y_cur > acc_y_max_q) acc_y_max_d = y_cur;
      if (acc_cnt_q != '1)     acc_cnt_d   = acc_cnt_q + 1'b1;
    end
  end

  // Results are captured on the edge that samples the last pixel, so they are visible
  // together with bbox_valid throughout the PUBLISH cycle.
  assign found = (acc_cnt_d != '0) && (acc_cnt_d >= min_pixels);

  always_comb begin
    out_x_min_d = out_x_min_q;
    out_x_max_d = out_x_max_q;
    out_y_min_d = out_y_min_q;
    out_y_max_d = out_y_max_q;
    out_cnt_d   = out_cnt_q;
    out_found_d = out_found_q;
    out_valid_d = 1'b0;
    if (last_pix) begin
      out_x_min_d = found ? acc_x_min_d : '0;
      out_x_max_d = found ? acc_x_max_d : '0;
      out_y_min_d = found ? acc_y_min_d : '0;
      out_y_max_d = found ? acc_y_max_d : '0;
      out_cnt_d   = acc_cnt_d;
      out_found_d = found;
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      pix_valid_q <= 1'b0;
      acc_x_min_q <= '1;
      acc_x_max_q <= '0;
      acc_y_min_q <= '1;
      acc_y_max_q <= '0;
      acc_cnt_q   <= '0;
      out_x_min_q <= '0;
      out_x_max_q <= '0;
      out_y_min_q <= '0;
      out_y_max_q <= '0;
      out_cnt_q   <= '0;
      out_found_q <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pix_valid_q <= is_not_blank;
      acc_x_min_q <= acc_x_min_d;
      acc_x_max_q <= acc_x_max_d;
      acc_y_min_q <= acc_y_min_d;
      acc_y_max_q <= acc_y_max_d;
      acc_cnt_q   <= acc_cnt_d;
      out_x_min_q <= out_x_min_d;
      out_x_max_q <= out_x_max_d;
      out_y_min_q <= out_y_min_d;
      out_y_max_q <= out_y_max_d;
      out_cnt_q   <= out_cnt_d;
      out_found_q <= out_found_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bbox_x_min   = out_x_min_q;
  assign bbox_x_max   = out_x_max_q;
  assign bbox_y_min   = out_y_min_q;
  assign bbox_y_max   = out_y_max_q;
  assign pixel_count  = out_cnt_q;
  assign object_found = out_found_q;
  assign bbox_valid   = out_valid_q;

endmodule

// File: doc/motion_bbox.md
MOTION_BBOX -- requirements
Module: motion_bbox

Interface
REQ-001 Parameter INPUT_WIDTH, default 10, SHALL set the width of the binary delta pixel from the delta stage.
REQ-002 Parameter H_ACTIVE, default 640, SHALL set the number of active pixels per line.
REQ-003 Parameter V_ACTIVE, default 480, SHALL set the number of active lines per frame.
REQ-004 Parameters X_WIDTH (10), Y_WIDTH (9) and CNT_WIDTH (19) SHALL set the coordinate and pixel-count widths.
REQ-005 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-006 reset  input  1  SHALL be the reset: synchronous, active-high.
REQ-007 frame_start  input  1  SHALL be a one-cycle pulse that precedes the first active pixel of a frame.
REQ-008 is_not_blank  input  1  SHALL mark active-video cycles, in the same cycle as the delta stage's input pixels.
REQ-009 delta_frame  input  INPUT_WIDTH  SHALL be the thresholded delta pixel; it lags is_not_blank by one cycle.
REQ-010 min_pixels  input  CNT_WIDTH  SHALL be the minimum motion-pixel count for the frame to declare an object.
REQ-011 bbox_x_min, bbox_x_max  output  X_WIDTH  SHALL give the motion bounding-box columns.
REQ-012 bbox_y_min, bbox_y_max  output  Y_WIDTH  SHALL give the motion bounding-box rows.
REQ-013 pixel_count  output  CNT_WIDTH  SHALL give the number of motion pixels in the last complete frame.
REQ-014 object_found  output  1  SHALL be high when the last published frame met min_pixels.
REQ-015 bbox_valid  output  1  SHALL pulse for exactly one cycle when the outputs update.

Function
REQ-016 The block SHALL delay is_not_blank by one register (pix_valid) to align it with delta_frame.
REQ-017 A pixel SHALL count as motion when pix_valid is 1 and delta_frame is nonzero.
REQ-018 The FSM states SHALL be IDLE, ACCUM and PUBLISH.
REQ-019 IDLE -> ACCUM on frame_start; ACCUM -> PUBLISH on the last pixel; PUBLISH -> IDLE after one cycle.
REQ-020 frame_start in any state SHALL clear x/y counters, pixel accumulators and box registers, and enter ACCUM.
REQ-021 frame_start SHALL override a simultaneous last pixel; that frame is discarded with no bbox_valid.
REQ-022 In ACCUM, x SHALL increment on each pix_valid and wrap to 0 at H_ACTIVE-1, with y incrementing on the wrap.
REQ-023 Counters SHALL hold on cycles where pix_valid is 0.
REQ-024 The last pixel SHALL be pix_valid with x=H_ACTIVE-1 and y=V_ACTIVE-1.
REQ-025 Accumulator start values SHALL be min=all-ones and max=0; each motion pixel updates min/max with its coordinates.
REQ-026 The internal count SHALL increment per motion pixel, saturating at all-ones.
REQ-027 pix_valid in IDLE or PUBLISH SHALL be ignored.
REQ-028 In PUBLISH the outputs SHALL update and bbox_valid SHALL be 1; outputs are registered and hold until the next PUBLISH.
REQ-029 object_found SHALL be (count != 0) and (count >= min_pixels), with min_pixels sampled in PUBLISH.
REQ-030 When object_found is 0, all four bbox outputs SHALL publish 0; pixel_count always publishes the true count.
REQ-031 bbox_valid SHALL rise exactly one cycle after the clock edge that samples the last pixel.

Reset
REQ-032 reset SHALL force state IDLE, counters and accumulators to start values, and all outputs to 0.
REQ-033 reset mid-frame SHALL discard the frame; no bbox_valid until a full frame follows a new frame_start.

Structure
REQ-034 Package motion_pkg SHALL hold default H_ACTIVE/V_ACTIVE, the X/Y/CNT widths and the FSM state enum.
REQ-035 Sub-module pixel_coord_counter SHALL own the x/y counters, wrap logic and last-pixel flag; motion_bbox owns the FSM and accumulators.

Verification (H_ACTIVE=8, V_ACTIVE=4, min_pixels=1 unless stated)
REQ-036 Reset held 3 cycles -> all outputs 0, bbox_valid 0, no pulse after release without frame_start.
REQ-037 Frame with a single motion pixel at (3,2) -> box x 3..3, y 2..2, pixel_count 1, object_found 1, one bbox_valid pulse.
REQ-038 Motion at (1,0), (6,3), (4,1) with random blanking gaps -> box x 1..6, y 0..3, count 3; gaps do not shift coordinates.
REQ-039 All-zero frame -> pixel_count 0, object_found 0, bbox all 0, bbox_valid still pulses.
REQ-040 frame_start mid-frame (y=2), then a full frame -> no pulse for the partial frame; the second frame is published correctly.
REQ-041 min_pixels=5 with 4 motion pixels -> object_found 0, box 0, pixel_count 4.
